// File: rtl/sub_share_arb_if.sv
// Request/response bundle between requesting datapath blocks and sub_share_arb.
//   enable   : gates new grants (requester side)
//   reqValid : per-requester operand-pair valid
//   reqA/B   : per-requester 4-bit minuend/subtrahend, requester i at [4i+3:4i]
//   reqReady : one-hot grant, combinational
//   rspValid/rspId/rspSub : registered tagged signed difference
//   busy     : registered, high while anything is in flight
interface sub_share_arb_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                 enable;
  logic [NUM_REQ-1:0]   reqValid;
  logic [NUM_REQ*4-1:0] reqA;
  logic [NUM_REQ*4-1:0] reqB;
  logic [NUM_REQ-1:0]   reqReady;
  logic                 rspValid;
  logic [IDW-1:0]       rspId;
  logic [4:0]           rspSub;
  logic                 busy;

  modport master (
    output enable, reqValid, reqA, reqB,
    input  reqReady, rspValid, rspId, rspSub, busy
  );

  modport slave (
    input  enable, reqValid, reqA, reqB,
    output reqReady, rspValid, rspId, rspSub, busy
  );
endinterface

// File: rtl/sub_share_arb.sv
// Round-robin arbiter sharing one 4-stage pipelined 4-bit subtractor among
// NUM_REQ requesters. Each grant issues the requester's operands tagged with
// its index; four cycles later a signed 5-bit A-B appears with that tag.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : sub_share_arb_if slave modport (request/grant/response signals)
module sub_share_arb #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic           clk,
  input  logic           rst,
  sub_share_arb_if.slave bus
);
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DW  = 5;

  logic [IDW-1:0] ptr;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   cand;
  logic           xfer;
  logic [3:0]     a_sel;
  logic [3:0]     b_sel;

  logic           s1_vld, s2_vld, s3_vld, s4_vld;
  logic [IDW-1:0] s1_id, s2_id, s3_id, s4_id;
  logic [DW-1:0]  s1_a, s1_b;
  logic [DW-1:0]  s2_d, s3_d, s4_d;
  logic           busy_q;

  // Round-robin search starting at ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) begin
        cand = cand - (IDW+1)'(NUM_REQ);
      end
      if (!gnt_vld && bus.reqValid[cand[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand[IDW-1:0];
      end
    end
  end

  // reset is included so no grant is shown while the block is held in reset
  assign xfer         = gnt_vld & bus.enable & ~rst;
  assign bus.reqReady = xfer ? (NUM_REQ'(1) << gnt_id) : '0;
  assign a_sel        = bus.reqA[{gnt_id, 2'b00} +: 4];
  assign b_sel        = bus.reqB[{gnt_id, 2'b00} +: 4];

  // Pointer advances past the granted requester only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  // Pipeline; idle stages carry zero tag/data so idle outputs read 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0; s1_id <= '0; s1_a <= '0; s1_b <= '0;
      s2_vld <= 1'b0; s2_id <= '0; s2_d <= '0;
      s3_vld <= 1'b0; s3_id <= '0; s3_d <= '0;
      s4_vld <= 1'b0; s4_id <= '0; s4_d <= '0;
      busy_q <= 1'b0;
    end else begin
      s1_vld <= xfer;
      s1_id  <= xfer ? gnt_id : '0;
      s1_a   <= xfer ? {1'b0, a_sel} : '0;
      s1_b   <= xfer ? {1'b0, b_sel} : '0;
      s2_vld <= s1_vld;
      s2_id  <= s1_id;
      s2_d   <= s1_a - s1_b;
      s3_vld <= s2_vld;
      s3_id  <= s2_id;
      s3_d   <= s2_d;
      s4_vld <= s3_vld;
      s4_id  <= s3_id;
      s4_d   <= s3_d;
      // OR of the stage valids as they will be after this edge
      busy_q <= xfer | s1_vld | s2_vld | s3_vld;
    end
  end

  assign bus.rspValid = s4_vld;
  assign bus.rspId    = s4_id;
  assign bus.rspSub   = s4_d;
  assign bus.busy     = busy_q;
endmodule
